// File: rtl/move_sequencer.sv
// move_sequencer: buffers up to DEPTH two-wheel moves and issues them one at a time
// to the left/right stepctl channels, with a settle gap and a busy-timeout fault.
module move_sequencer #(
   parameter int unsigned DEPTH   = 4,
   parameter logic [15:0] SETTLE  = 16'd5000,
   parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
   input  logic        WF_CLK,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic [33:0] cmd_data,
   output logic        cmd_ready,
   input  logic        start,
   input  logic        abort,
   input  logic        motorL_busy,
   input  logic        motorR_busy,
   output logic        motorL_go,
   output logic        motorR_go,
   output logic [15:0] motorL_target,
   output logic [15:0] motorR_target,
   output logic        motorL_dir,
   output logic        motorR_dir,
   output logic        running,
   output logic        seq_done,
   output logic        fault
);

   localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned   CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [31:0]   TMO_MAX = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_ISSUE  = 3'd2,
      S_HOLD   = 3'd3,
      S_RUN    = 3'd4,
      S_SETTLE = 3'd5,
      S_DRAIN  = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [33:0]   fifo_mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_s;
   logic [33:0]   head_s;
   logic          push_s;
   logic          pop_s;
   logic          flush_s;
   logic          fifo_empty_s;
   logic          both_idle_s;
   logic          settle_last_s;
   logic          tmo_hit_s;
   logic          hold_cnt_r;
   logic [15:0]   settle_cnt_r;
   logic [31:0]   tmo_cnt_r;
   logic          cmd_ready_r;
   logic          go_left_r;
   logic          go_right_r;
   logic          dir_left_r;
   logic          dir_right_r;
   logic [15:0]   target_left_r;
   logic [15:0]   target_right_r;
   logic          running_r;
   logic          seq_done_r;
   logic          fault_r;

   // FIFO handshake decode and status flags
   always_comb begin
      flush_s       = abort && (state_r != S_IDLE);
      push_s        = cmd_valid && cmd_ready_r && !flush_s;
      pop_s         = (state_r == S_LOAD) && !flush_s;
      fifo_empty_s  = (count_r == {CW{1'b0}});
      head_s        = fifo_mem_r[rd_ptr_r];
      both_idle_s   = !motorL_busy && !motorR_busy;
      settle_last_s = (({1'b0, settle_cnt_r} + 17'd1) >= {1'b0, SETTLE});
      tmo_hit_s     = (tmo_cnt_r >= TIMEOUT);
      if (flush_s) begin
         count_s = {CW{1'b0}};
      end else begin
         count_s = count_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
      end
   end

   // Next-state logic; a flush overrides every state except IDLE
   always_comb begin
      state_s = state_r;
      if (flush_s) begin
         state_s = S_DRAIN;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start && !fifo_empty_s) state_s = S_LOAD;
               else                        state_s = S_IDLE;
            end
            S_LOAD: begin
               if (head_s[31:0] == 32'd0) state_s = S_SETTLE;
               else                       state_s = S_ISSUE;
            end
            S_ISSUE: state_s = S_HOLD;
            S_HOLD: begin
               if (hold_cnt_r) state_s = S_RUN;
               else            state_s = S_HOLD;
            end
            S_RUN: begin
               if (both_idle_s)    state_s = S_SETTLE;
               else if (tmo_hit_s) state_s = S_FAULT;
               else                state_s = S_RUN;
            end
            S_SETTLE: begin
               if (!settle_last_s)     state_s = S_SETTLE;
               else if (fifo_empty_s)  state_s = S_IDLE;
               else                    state_s = S_LOAD;
            end
            S_DRAIN: begin
               if (both_idle_s) state_s = S_IDLE;
               else             state_s = S_DRAIN;
            end
            S_FAULT: state_s = S_FAULT;
            default: state_s = S_IDLE;
         endcase
      end
   end

   // FIFO storage; count gates every read so contents need no reset
   always_ff @(posedge WF_CLK) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r] <= cmd_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH
   always_ff @(posedge WF_CLK) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush_s) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
         count_r <= count_s;
      end
   end

   // State register plus HOLD, SETTLE and timeout counters
   always_ff @(posedge WF_CLK) begin
      if (!rst_n) begin
         state_r      <= S_IDLE;
         hold_cnt_r   <= 1'b0;
         settle_cnt_r <= 16'd0;
         tmo_cnt_r    <= 32'd0;
      end else begin
         state_r      <= state_s;
         hold_cnt_r   <= (state_r == S_HOLD) && !hold_cnt_r;
         settle_cnt_r <= (state_r == S_SETTLE) ? (settle_cnt_r + 16'd1) : 16'd0;
         // ISSUE counts as the first timed cycle, so LOAD preloads one
         if (state_r == S_LOAD) begin
            tmo_cnt_r <= 32'd1;
         end else if (((state_r == S_ISSUE) || (state_r == S_HOLD) || (state_r == S_RUN))
                      && (tmo_cnt_r != TMO_MAX)) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
         end
      end
   end

   // Registered outputs; dir/target only move in LOAD so a wheel never flips mid-move
   always_ff @(posedge WF_CLK) begin
      if (!rst_n) begin
         cmd_ready_r    <= 1'b0;
         go_left_r      <= 1'b0;
         go_right_r     <= 1'b0;
         dir_left_r     <= 1'b0;
         dir_right_r    <= 1'b0;
         target_left_r  <= 16'd0;
         target_right_r <= 16'd0;
         running_r      <= 1'b0;
         seq_done_r     <= 1'b0;
         fault_r        <= 1'b0;
      end else begin
         cmd_ready_r <= (count_s < DEPTH_C);
         go_left_r   <= (state_r == S_LOAD) && (state_s == S_ISSUE) && (head_s[31:16] != 16'd0);
         go_right_r  <= (state_r == S_LOAD) && (state_s == S_ISSUE) && (head_s[15:0] != 16'd0);
         if (pop_s) begin
            dir_left_r     <= head_s[33];
            dir_right_r    <= head_s[32];
            target_left_r  <= head_s[31:16];
            target_right_r <= head_s[15:0];
         end
         running_r  <= (state_s != S_IDLE) && (state_s != S_FAULT);
         seq_done_r <= ((state_r == S_IDLE) && start && fifo_empty_s) ||
                       ((state_r == S_SETTLE) && (state_s == S_IDLE));
         if (state_s == S_FAULT)     fault_r <= 1'b1;
         else if (state_s == S_IDLE) fault_r <= 1'b0;
      end
   end

   assign cmd_ready     = cmd_ready_r;
   assign motorL_go     = go_left_r;
   assign motorR_go     = go_right_r;
   assign motorL_dir    = dir_left_r;
   assign motorR_dir    = dir_right_r;
   assign motorL_target = target_left_r;
   assign motorR_target = target_right_r;
   assign running       = running_r;
   assign seq_done      = seq_done_r;
   assign fault         = fault_r;

endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed + randomized move lists against a queue-based
// event-level model of the sequencer (FIFO order, go timing, settle, fault).
module tb_move_sequencer;

   localparam int DEPTH     = 4;
   localparam int SETTLE_P  = 7;
   localparam int TIMEOUT_P = 1000;

   logic        WF_CLK = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic [33:0] cmd_data;
   logic        cmd_ready;
   logic        start;
   logic        abort;
   logic        motorL_busy;
   logic        motorR_busy;
   logic        motorL_go;
   logic        motorR_go;
   logic [15:0] motorL_target;
   logic [15:0] motorR_target;
   logic        motorL_dir;
   logic        motorR_dir;
   logic        running;
   logic        seq_done;
   logic        fault;

   int          checks = 0;
   int          errors = 0;
   logic [33:0] model_q[$];
   logic [33:0] prev_cmd;

   always #5 WF_CLK = ~WF_CLK;

   move_sequencer #(
      .DEPTH   (DEPTH),
      .SETTLE  (16'(SETTLE_P)),
      .TIMEOUT (32'(TIMEOUT_P))
   ) dut (
      .WF_CLK        (WF_CLK),
      .rst_n         (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_data      (cmd_data),
      .cmd_ready     (cmd_ready),
      .start         (start),
      .abort         (abort),
      .motorL_busy   (motorL_busy),
      .motorR_busy   (motorR_busy),
      .motorL_go     (motorL_go),
      .motorR_go     (motorR_go),
      .motorL_target (motorL_target),
      .motorR_target (motorR_target),
      .motorL_dir    (motorL_dir),
      .motorR_dir    (motorR_dir),
      .running       (running),
      .seq_done      (seq_done),
      .fault         (fault)
   );

   task automatic step();
      @(negedge WF_CLK);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [33:0] outs();
      return {motorL_dir, motorR_dir, motorL_target, motorR_target};
   endfunction

   function automatic logic [33:0] rand_cmd(input bit allow_zero);
      logic [15:0] tl;
      logic [15:0] tr;
      tl = (allow_zero && $urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      tr = (allow_zero && $urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      return {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tl, tr};
   endfunction

   task automatic push(input logic [33:0] d);
      chk("push_ready", cmd_ready, model_q.size() < DEPTH);
      cmd_valid = 1'b1;
      cmd_data  = d;
      if (model_q.size() < DEPTH) model_q.push_back(d);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic start_empty();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("empty_done", seq_done, 1'b1);
      chk("empty_running", running, 1'b0);
      step();
      chk("empty_done_clr", seq_done, 1'b0);
   endtask

   // Called at the LOAD cycle of the next queued move; returns at the cycle after SETTLE.
   task automatic exec_move(input int fixed_dur);
      logic [33:0] c;
      logic        act_l;
      logic        act_r;
      int          dl;
      int          dr;
      int          k;
      c     = model_q.pop_front();
      act_l = (c[31:16] != 16'd0);
      act_r = (c[15:0] != 16'd0);
      chk("load_go", {motorL_go, motorR_go}, 2'b00);
      chk("load_running", running, 1'b1);
      chk("load_done", seq_done, 1'b0);
      chk("load_outs_held", outs(), prev_cmd);
      step();
      if (act_l || act_r) begin
         chk("issue_go", {motorL_go, motorR_go}, {act_l, act_r});
         chk("issue_outs", outs(), c);
         motorL_busy = act_l;
         motorR_busy = act_r;
         dl = (fixed_dur >= 0) ? fixed_dur : int'($urandom_range(0, 20));
         dr = (fixed_dur >= 0) ? fixed_dur : int'($urandom_range(0, 20));
         for (int h = 0; h < 2; h++) begin
            step();
            chk("hold_go", {motorL_go, motorR_go}, 2'b00);
            chk("hold_outs", outs(), c);
         end
         k = 0;
         do begin
            step();
            motorL_busy = act_l && (k < dl);
            motorR_busy = act_r && (k < dr);
            chk("run_go", {motorL_go, motorR_go}, 2'b00);
            chk("run_outs", outs(), c);
            k++;
         end while (motorL_busy || motorR_busy);
         step();
      end
      for (int s = 0; s < SETTLE_P; s++) begin
         chk("settle_go", {motorL_go, motorR_go}, 2'b00);
         chk("settle_done", seq_done, 1'b0);
         chk("settle_outs", outs(), c);
         step();
      end
      prev_cmd = c;
   endtask

   task automatic run_queue(input int fixed_dur);
      start = 1'b1;
      step();
      start = 1'b0;
      while (model_q.size() > 0) exec_move(fixed_dur);
      chk("done_pulse", seq_done, 1'b1);
      chk("done_running", running, 1'b0);
      step();
      chk("done_clear", seq_done, 1'b0);
   endtask

   initial begin
      logic [33:0] c;
      int          n;
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_data    = 34'd0;
      start       = 1'b0;
      abort       = 1'b0;
      motorL_busy = 1'b0;
      motorR_busy = 1'b0;
      prev_cmd    = 34'd0;
      repeat (3) step();

      // Reset state and cmd_ready release timing
      chk("reset_outs", {cmd_ready, motorL_go, motorR_go, running, seq_done, fault, outs()}, 40'd0);
      rst_n = 1'b1;
      chk("ready_before_release", cmd_ready, 1'b0);
      step();
      chk("ready_after_release", cmd_ready, 1'b1);

      start_empty();

      // Single 18000/18000 move with a 100-cycle busy window
      push({1'b0, 1'b0, 16'd18000, 16'd18000});
      run_queue(97);

      // Four mixed-direction moves, a rejected fifth push, then in-order execution
      for (int i = 0; i < 4; i++) push(rand_cmd(1'b0));
      chk("full_ready", cmd_ready, 1'b0);
      push(rand_cmd(1'b0));
      run_queue(-1);

      // Single-wheel and all-zero moves
      push({1'b0, 1'b0, 16'd0, 16'd500});
      push(34'd0);
      run_queue(-1);

      // Randomized move lists
      repeat (5) begin
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) push(rand_cmd(1'b1));
         run_queue(-1);
      end

      // Timeout: left wheel never finishes
      c = {1'b1, 1'b0, 16'd300, 16'd40};
      push(c);
      start = 1'b1;
      step();
      start = 1'b0;
      void'(model_q.pop_front());
      step();
      chk("tmo_issue_go", {motorL_go, motorR_go}, 2'b11);
      motorL_busy = 1'b1;
      motorR_busy = 1'b1;
      step();
      step();
      step();
      motorR_busy = 1'b0;
      push(rand_cmd(1'b0));
      repeat (TIMEOUT_P - 5) step();
      chk("tmo_fault_early", fault, 1'b0);
      chk("tmo_running_early", running, 1'b1);
      step();
      chk("tmo_fault_rise", fault, 1'b1);
      chk("tmo_running_fall", running, 1'b0);
      repeat (10) step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      chk("fault_sticky", fault, 1'b1);
      chk("fault_start_ignored", {motorL_go, motorR_go, running}, 3'b000);
      chk("fault_fifo_kept", cmd_ready, model_q.size() < DEPTH);
      abort = 1'b1;
      step();
      abort = 1'b0;
      model_q.delete();
      repeat (4) begin
         step();
         chk("drain_go", {motorL_go, motorR_go}, 2'b00);
      end
      chk("drain_fault_held", fault, 1'b1);
      motorL_busy = 1'b0;
      step();
      chk("drain_exit", {fault, seq_done, running}, 3'b000);
      prev_cmd = c;
      start_empty();

      // Abort in RUN with two entries queued and a coincident push
      for (int i = 0; i < 3; i++) push(rand_cmd(1'b0));
      start = 1'b1;
      step();
      start = 1'b0;
      c = model_q.pop_front();
      step();
      chk("abort_issue_go", {motorL_go, motorR_go}, 2'b11);
      motorL_busy = 1'b1;
      motorR_busy = 1'b1;
      repeat (3) step();
      abort     = 1'b1;
      cmd_valid = 1'b1;
      cmd_data  = rand_cmd(1'b0);
      step();
      abort     = 1'b0;
      cmd_valid = 1'b0;
      model_q.delete();
      chk("abort_running", running, 1'b1);
      repeat (3) begin
         step();
         chk("abort_drain_quiet", {motorL_go, motorR_go, seq_done}, 3'b000);
      end
      motorL_busy = 1'b0;
      motorR_busy = 1'b0;
      step();
      chk("abort_idle", {running, seq_done}, 2'b00);
      chk("abort_ready", cmd_ready, 1'b1);
      repeat (SETTLE_P + 4) begin
         step();
         chk("abort_no_go", {motorL_go, motorR_go, seq_done}, 3'b000);
      end
      prev_cmd = c;
      start_empty();

      // One-cycle reset in the middle of RUN
      push(rand_cmd(1'b0));
      push(rand_cmd(1'b0));
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      motorL_busy = 1'b1;
      motorR_busy = 1'b1;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("midreset_outs", {cmd_ready, motorL_go, motorR_go, running, seq_done, fault, outs()}, 40'd0);
      model_q.delete();
      prev_cmd = 34'd0;
      step();
      chk("midreset_ready", cmd_ready, 1'b1);
      motorL_busy = 1'b0;
      motorR_busy = 1'b0;
      start_empty();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Command sequencer for the two encoder-driven step controllers (`stepctl`) on the robot top level. It buffers up to four queued moves, each with a per-wheel direction and encoder-tick target. On a start pulse it issues the moves one at a time to both wheel channels. It waits for both channels to finish, inserts a settle gap, and flags completion or a timeout fault. It replaces the hard-wired single-move button trigger with a programmable move list.

## Interface
- `DEPTH`, 4 — command FIFO entries (power of two, 2..16)
- `SETTLE`, 16'd5000 — idle cycles inserted after each move before the next is issued
- `TIMEOUT`, 32'd50_000_000 — max cycles a move may stay busy before fault
- `WF_CLK`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  command push request
- `cmd_data`  in  34  {dirL, dirR, targetL[15:0], targetR[15:0]}
- `cmd_ready`  out  1  FIFO not full; push occurs on `cmd_valid & cmd_ready`
- `start`  in  1  single-cycle pulse, begins executing the queue
- `abort`  in  1  single-cycle pulse, flushes queue and stops sequencing
- `motorL_busy`, `motorR_busy`  in  1 each  stepctl enable outputs (high while moving)
- `motorL_go`, `motorR_go`  out  1 each  one-cycle trigger to stepctl
- `motorL_target`, `motorR_target`  out  16 each  tick target presented to stepctl
- `motorL_dir`, `motorR_dir`  out  1 each  wheel direction pins
- `running`  out  1  high from start acceptance until DONE/IDLE/FAULT
- `seq_done`  out  1  one-cycle pulse when the queue empties normally
- `fault`  out  1  sticky timeout flag

## Operation
- States: IDLE, LOAD, ISSUE, HOLD, RUN, SETTLE, DRAIN, FAULT.
- IDLE: `start` with a non-empty FIFO goes to LOAD. `start` with an empty FIFO raises `seq_done` for one cycle and stays in IDLE. `start` outside IDLE is ignored.
- LOAD: pops one entry and latches the dir and target registers. If both targets are 0, go to SETTLE (no trigger issued). Otherwise go to ISSUE.
- ISSUE: assert `go` for one cycle on each channel with a non-zero target. Go to HOLD.
- HOLD: two fixed cycles. Busy inputs are ignored here to cover stepctl trigger latency. Then go to RUN.
- RUN: wait until both busy inputs are low, then go to SETTLE. The timeout counter starts at ISSUE. If it reaches `TIMEOUT`, go to FAULT.
- SETTLE: count `SETTLE` cycles. Then go to LOAD if the FIFO is non-empty. Otherwise pulse `seq_done` and go to IDLE.
- Direction and target outputs change only in LOAD. They are held stable through ISSUE..SETTLE so a direction never flips while a wheel is enabled.
- `abort`, in any state except IDLE: flush the FIFO, then go to DRAIN. DRAIN waits for both busy inputs low, then goes to IDLE with no `seq_done`. stepctl has no stop input, so an in-flight move completes.
- FAULT: `fault`=1, `running`=0, FIFO retained. Only `abort` or reset exits. `abort` goes through DRAIN to IDLE and clears `fault` on IDLE entry.
- FIFO: push is accepted in every state, including during a run, and pushed entries join the current sequence. Push and pop in the same cycle keep the count unchanged. Pointers wrap modulo `DEPTH`. Push while full is impossible because `cmd_ready`=0. If `abort` coincides with a push, the flush wins and the pushed entry is discarded.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, FIFO empty, and all outputs 0. This includes `cmd_ready`, which rises the first cycle after reset release. A mid-run reset drops sequencing immediately, whatever the stepctl state.
- Cycle timeline, `start` sampled at edge t:
  - LOAD during t+1
  - `go` high during t+2
  - HOLD during t+3 and t+4
  - RUN from t+5
- After both busy inputs are seen low at edge r: SETTLE occupies r+1..r+SETTLE, and the next LOAD or the `seq_done` pulse occurs at r+SETTLE+1.
- Timeout counter: 32-bit, saturating, reset at ISSUE. It compares `>= TIMEOUT`.
- SETTLE counter: 16-bit. `SETTLE`=0 means one cycle in SETTLE.

## Test plan
- Push one command {0,0,18000,18000}, pulse `start`, model busy for 100 cycles → `go` pulse on both channels at t+2, targets 18000, `seq_done` exactly SETTLE+1 cycles after busy falls.
- Push 4 commands with mixed directions, and push a 5th → `cmd_ready`=0 after the 4th. Run → dir pins change only between moves, and 4 `go` pairs are issued in FIFO order.
- Command with targetL=0, targetR=500 → only `motorR_go` pulses. Command {0,0,0,0} → no `go`, goes straight to SETTLE.
- Hold `motorL_busy` high forever with TIMEOUT=1000 → `fault` rises 1000 cycles after ISSUE and stays high. `abort` → DRAIN until busy is released, then IDLE with `fault`=0.
- `abort` during RUN with 2 entries queued → FIFO empty, no further `go`, no `seq_done`, and `running` falls once busy is low.
- `rst_n` low for one cycle mid-RUN → all outputs 0, `cmd_ready`=1 next cycle, queue empty.
